// File: rtl/pipeline_retire_tracker_if.sv
// Fetch/hazard inputs, retire-record handshake and status counters of the
// retire tracker, bundled so the core side and the logger side share one port.
interface pipeline_retire_tracker_if #(
   parameter int FIFO_DEPTH = 8,
   parameter int SEQ_W      = 16,
   parameter int CYC_W      = 32
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             fetch_valid;
   logic [15:0]      fetch_pc;
   logic [15:0]      fetch_instr;
   logic             stall;
   logic             flush;
   logic             ret_ready;
   logic             ret_valid;
   logic [SEQ_W-1:0] ret_seq;
   logic [15:0]      ret_pc;
   logic [15:0]      ret_instr;
   logic [CYC_W-1:0] ret_cycle;
   logic [CNT_W-1:0] fifo_count;
   logic             overflow;
   logic [7:0]       drop_cnt;
   logic [7:0]       squash_cnt;

   modport master (
      output fetch_valid, fetch_pc, fetch_instr, stall, flush, ret_ready,
      input  ret_valid, ret_seq, ret_pc, ret_instr, ret_cycle,
             fifo_count, overflow, drop_cnt, squash_cnt
   );

   modport slave (
      input  fetch_valid, fetch_pc, fetch_instr, stall, flush, ret_ready,
      output ret_valid, ret_seq, ret_pc, ret_instr, ret_cycle,
             fifo_count, overflow, drop_cnt, squash_cnt
   );
endinterface

// File: rtl/pipeline_retire_tracker.sv
// Shadows the IF/ID/EX/MEM/WB pipeline with sequence tags and turns every WB
// instruction into a retire record held in a first-word-fall-through FIFO.
module pipeline_retire_tracker #(
   parameter int FIFO_DEPTH = 8,
   parameter int SEQ_W      = 16,
   parameter int CYC_W      = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pipeline_retire_tracker_if.slave bus
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int STAGES = 4;
   localparam int S_ID   = 0;
   localparam int S_EX   = 1;
   localparam int S_MEM  = 2;
   localparam int S_WB   = 3;

   typedef struct packed {
      logic [SEQ_W-1:0] seq;
      logic [15:0]      pc;
      logic [15:0]      instr;
   } tag_t;

   typedef struct packed {
      tag_t             tag;
      logic [CYC_W-1:0] cycle;
   } rec_t;

   // Pipeline shadow state
   logic [STAGES-1:0]       r_vld_pipe;
   tag_t [STAGES-1:0]       r_tag;
   logic [SEQ_W-1:0]        r_seq;
   logic [CYC_W-1:0]        r_cycle;
   logic [7:0]              r_squash_cnt;

   // Retire FIFO state
   rec_t                    r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]        r_count;
   logic                    r_overflow;
   logic [7:0]              r_drop_cnt;

   logic                    w_accept;
   logic [1:0]              w_squash_inc;
   logic [8:0]              w_squash_sum;
   logic [8:0]              w_drop_sum;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_wr;
   logic                    w_drop;
   logic                    w_empty;
   logic                    w_full;
   rec_t                    w_rec;
   rec_t                    w_head;

   assign w_accept     = bus.fetch_valid & ~bus.stall & ~bus.flush;
   assign w_squash_inc = bus.flush ? (2'(r_vld_pipe[S_ID]) + 2'(bus.fetch_valid)) : 2'd0;
   assign w_squash_sum = {1'b0, r_squash_cnt} + 9'(w_squash_inc);
   assign w_drop_sum   = {1'b0, r_drop_cnt} + 9'd1;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_push  = r_vld_pipe[S_WB];
   assign w_pop   = ~w_empty & bus.ret_ready;
   // A full FIFO still takes the record when the head leaves on the same edge.
   assign w_wr    = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;

   assign w_rec.tag   = r_tag[S_WB];
   assign w_rec.cycle = r_cycle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe   <= '0;
         r_tag        <= '0;
         r_seq        <= '0;
         r_cycle      <= '0;
         r_squash_cnt <= '0;
      end else begin
         r_cycle          <= r_cycle + CYC_W'(1);
         r_vld_pipe[S_WB] <= r_vld_pipe[S_MEM];
         r_tag[S_WB]      <= r_tag[S_MEM];
         r_vld_pipe[S_MEM] <= r_vld_pipe[S_EX];
         r_tag[S_MEM]     <= r_tag[S_EX];
         if (bus.flush) begin
            // Flush overrides stall: both ID and EX become bubbles.
            r_vld_pipe[S_ID] <= 1'b0;
            r_vld_pipe[S_EX] <= 1'b0;
            r_squash_cnt     <= w_squash_sum[8] ? 8'hFF : w_squash_sum[7:0];
         end else if (bus.stall) begin
            r_vld_pipe[S_EX] <= 1'b0;
         end else begin
            r_vld_pipe[S_EX] <= r_vld_pipe[S_ID];
            r_tag[S_EX]      <= r_tag[S_ID];
            r_vld_pipe[S_ID] <= w_accept;
            if (w_accept) begin
               r_tag[S_ID].seq   <= r_seq;
               r_tag[S_ID].pc    <= bus.fetch_pc;
               r_tag[S_ID].instr <= bus.fetch_instr;
               r_seq             <= r_seq + SEQ_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_wr && !w_pop)
            r_count <= r_count + CNT_W'(1);
         else if (!w_wr && w_pop)
            r_count <= r_count - CNT_W'(1);
         if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
         end
      end
   end

   // Storage needs no reset: head outputs are gated by occupancy.
   always_ff @(posedge clk) begin
      if (w_wr)
         r_fifo[r_wr_ptr] <= w_rec;
   end

   assign w_head = r_fifo[r_rd_ptr];

   assign bus.ret_valid  = ~w_empty;
   assign bus.ret_seq    = w_empty ? '0 : w_head.tag.seq;
   assign bus.ret_pc     = w_empty ? '0 : w_head.tag.pc;
   assign bus.ret_instr  = w_empty ? '0 : w_head.tag.instr;
   assign bus.ret_cycle  = w_empty ? '0 : w_head.cycle;
   assign bus.fifo_count = r_count;
   assign bus.overflow   = r_overflow;
   assign bus.drop_cnt   = r_drop_cnt;
   assign bus.squash_cnt = r_squash_cnt;
endmodule

// File: tb/tb_pipeline_retire_tracker.sv
// Scoreboard bench for pipeline_retire_tracker: expected retire records are
// queued as fetches are driven and compared whenever the logger side pops.
module tb_pipeline_retire_tracker;
   typedef struct {
      logic [15:0] seq;
      logic [15:0] pc;
      logic [15:0] instr;
      logic [31:0] cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] tb_cyc;
   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;

   pipeline_retire_tracker_if #(.FIFO_DEPTH(8), .SEQ_W(16), .CYC_W(32)) bus ();

   pipeline_retire_tracker #(.FIFO_DEPTH(8), .SEQ_W(16), .CYC_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Edge index since reset release: the value seen at a negedge is the upcoming edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_cyc <= 0;
      else        tb_cyc <= tb_cyc + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] mk_instr(input logic [15:0] pc);
      return {pc[7:0] ^ 8'h5A, pc[15:8] + 8'h3C};
   endfunction

   task automatic push_exp(input logic [15:0] seq, input logic [15:0] pc, input logic [31:0] cyc);
      exp_t e;
      e.seq = seq; e.pc = pc; e.instr = mk_instr(pc); e.cyc = cyc;
      sb.push_back(e);
   endtask

   // Pops the scoreboard when the upcoming edge will pop the DUT FIFO.
   task automatic mon_pop();
      exp_t e;
      if (rst_n && bus.ret_valid && bus.ret_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_record: got seq=%0d pc=%h cycle=%0d, expected no record",
                     bus.ret_seq, bus.ret_pc, bus.ret_cycle);
         end else begin
            e = sb.pop_front();
            if ({bus.ret_seq, bus.ret_pc, bus.ret_instr, bus.ret_cycle} !== {e.seq, e.pc, e.instr, e.cyc}) begin
               errors++;
               $display("FAIL record: got seq=%0d pc=%h instr=%h cycle=%0d, expected seq=%0d pc=%h instr=%h cycle=%0d",
                        bus.ret_seq, bus.ret_pc, bus.ret_instr, bus.ret_cycle, e.seq, e.pc, e.instr, e.cyc);
            end
         end
      end
   endtask

   // Called at a negedge: applies inputs for the next posedge, returns at the following negedge.
   task automatic drive(input logic fv, input logic [15:0] pc, input logic st, input logic fl);
      bus.fetch_valid = fv;
      bus.fetch_pc    = pc;
      bus.fetch_instr = mk_instr(pc);
      bus.stall       = st;
      bus.flush       = fl;
      #1;
      mon_pop();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.fetch_valid = 0; bus.fetch_pc = 0; bus.fetch_instr = 0;
      bus.stall = 0; bus.flush = 0; bus.ret_ready = 0;
      repeat (2) @(negedge clk);
      sb.delete();
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         drive(0, 16'h0, 0, 0);
         n++;
      end
      repeat (4) drive(0, 16'h0, 0, 0);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d records pending after %0d cycles, expected 0", name, sb.size(), n);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({bus.ret_valid, bus.fifo_count, bus.overflow} !== 6'd0) begin
         errors++;
         $display("FAIL reset_status: got valid=%0d count=%0d ovf=%0d, expected 0 0 0",
                  bus.ret_valid, bus.fifo_count, bus.overflow);
      end
      checks++;
      if ({bus.drop_cnt, bus.squash_cnt} !== 16'd0) begin
         errors++;
         $display("FAIL reset_counters: got drop=%0d squash=%0d, expected 0 0", bus.drop_cnt, bus.squash_cnt);
      end
      checks++;
      if ({bus.ret_seq, bus.ret_pc, bus.ret_instr, bus.ret_cycle} !== 80'd0) begin
         errors++;
         $display("FAIL reset_head: got seq=%0d pc=%h instr=%h cycle=%0d, expected all 0",
                  bus.ret_seq, bus.ret_pc, bus.ret_instr, bus.ret_cycle);
      end
   endtask

   task automatic test_in_order();
      do_reset();
      bus.ret_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_exp(16'(i), 16'(2 * i), 32'(4 + i));
         drive(1, 16'(2 * i), 0, 0);
      end
      drive(0, 16'h0, 0, 0);
      checks++;
      if (bus.ret_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: got ret_valid=%0d after edge 3, expected 0", bus.ret_valid);
      end
      drive(0, 16'h0, 0, 0);
      checks++;
      if (bus.ret_valid !== 1'b1 || bus.ret_seq !== 16'd0) begin
         errors++;
         $display("FAIL latency_first: got ret_valid=%0d seq=%0d after edge 4, expected 1 0",
                  bus.ret_valid, bus.ret_seq);
      end
      wait_drain("in_order");
   endtask

   task automatic test_stall();
      do_reset();
      bus.ret_ready = 1'b1;
      push_exp(16'd0, 16'h0010, tb_cyc + 4);
      drive(1, 16'h0010, 0, 0);
      push_exp(16'd1, 16'h0012, tb_cyc + 6);
      drive(1, 16'h0012, 0, 0);
      drive(1, 16'h0014, 1, 0);
      drive(1, 16'h0014, 1, 0);
      push_exp(16'd2, 16'h0014, tb_cyc + 4);
      drive(1, 16'h0014, 0, 0);
      wait_drain("stall");
      checks++;
      if (bus.squash_cnt !== 8'd0) begin
         errors++;
         $display("FAIL stall_squash: got squash_cnt=%0d, expected 0", bus.squash_cnt);
      end
   endtask

   task automatic test_flush();
      do_reset();
      bus.ret_ready = 1'b1;
      push_exp(16'd0, 16'h0020, tb_cyc + 4);
      drive(1, 16'h0020, 0, 0);
      drive(1, 16'h0022, 0, 0);
      drive(1, 16'h0024, 0, 1);
      checks++;
      if (bus.squash_cnt !== 8'd2) begin
         errors++;
         $display("FAIL flush_squash: got squash_cnt=%0d, expected 2", bus.squash_cnt);
      end
      push_exp(16'd2, 16'h0026, tb_cyc + 4);
      drive(1, 16'h0026, 0, 0);
      wait_drain("flush");
   endtask

   task automatic test_stall_flush();
      do_reset();
      bus.ret_ready = 1'b1;
      drive(1, 16'h0030, 0, 0);
      drive(1, 16'h0032, 1, 1);
      push_exp(16'd1, 16'h0034, tb_cyc + 4);
      drive(1, 16'h0034, 0, 0);
      checks++;
      if (bus.squash_cnt !== 8'd2) begin
         errors++;
         $display("FAIL stall_flush_squash: got squash_cnt=%0d, expected 2", bus.squash_cnt);
      end
      wait_drain("stall_flush");
   endtask

   task automatic test_overflow();
      do_reset();
      bus.ret_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i < 8) push_exp(16'(i), 16'(16'h0100 + 2 * i), tb_cyc + 4);
         drive(1, 16'(16'h0100 + 2 * i), 0, 0);
      end
      repeat (6) drive(0, 16'h0, 0, 0);
      checks++;
      if (bus.fifo_count !== 4'd8) begin
         errors++;
         $display("FAIL overflow_count: got fifo_count=%0d, expected 8", bus.fifo_count);
      end
      checks++;
      if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd2) begin
         errors++;
         $display("FAIL overflow_flags: got overflow=%0d drop_cnt=%0d, expected 1 2", bus.overflow, bus.drop_cnt);
      end
      bus.ret_ready = 1'b1;
      wait_drain("overflow");
      checks++;
      if (bus.overflow !== 1'b1 || bus.fifo_count !== 4'd0) begin
         errors++;
         $display("FAIL overflow_sticky: got overflow=%0d fifo_count=%0d, expected 1 0", bus.overflow, bus.fifo_count);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.ret_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i < 12) push_exp(16'(i), 16'(16'h0200 + 2 * i), tb_cyc + 4);
         bus.ret_ready = (i >= 12);
         drive(i < 12, 16'(16'h0200 + 2 * i), 0, 0);
      end
      checks++;
      if (bus.fifo_count !== 4'd8) begin
         errors++;
         $display("FAIL full_push_pop_count: got fifo_count=%0d, expected 8", bus.fifo_count);
      end
      checks++;
      if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL full_push_pop_drop: got overflow=%0d drop_cnt=%0d, expected 0 0", bus.overflow, bus.drop_cnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.ret_valid !== 1'b0 || bus.fifo_count !== 4'd0) begin
         errors++;
         $display("FAIL async_reset: got ret_valid=%0d fifo_count=%0d, expected 0 0", bus.ret_valid, bus.fifo_count);
      end
      do_reset();
      bus.ret_ready = 1'b1;
      repeat (8) drive(0, 16'h0, 0, 0);
      checks++;
      if (bus.ret_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_discard: got ret_valid=%0d after reset, expected 0", bus.ret_valid);
      end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_stall();
      test_flush();
      test_stall_flush();
      test_overflow();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
